// File: rtl/mem_stage_ls_pkg.sv
// Shared types and layout constants for the memory stage.
package mem_stage_ls_pkg;

  // Access size as encoded on sizeM
  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  // Wait-state machine for multi-cycle RAM accesses
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  // MEM/WB control bits: regWrite, mem2reg, memWrite, misalign
  localparam int MEMWB_CTRL_W = 4;

  // MEM/WB layout: readData, ALUResult, writeReg, control bits
  function automatic int memwb_width(input int word, input int reg_size);
    return 2 * word + reg_size + MEMWB_CTRL_W;
  endfunction

endpackage

// File: rtl/mem_stage_ls_if.sv
// Execute->memory inputs and memory->writeback outputs of the memory stage.
interface mem_stage_ls_if #(
  parameter int WORD     = 32,
  parameter int REG_SIZE = 5
);
  logic [WORD-1:0]     ALUResultM;
  logic [WORD-1:0]     writeDataM;
  logic [REG_SIZE-1:0] writeRegM;
  logic                regWriteM;
  logic                memWriteM;
  logic                mem2regM;
  logic [1:0]          sizeM;
  logic                unsignedM;
  logic                flushM;
  logic                zeroM;
  logic                branchM;

  logic                stallM;
  logic                PCSrcM;
  logic [WORD-1:0]     readDataW;
  logic [WORD-1:0]     ALUResultW;
  logic [REG_SIZE-1:0] writeRegW;
  logic                regWriteW;
  logic                mem2regW;
  logic                memWriteW;
  logic                misalignW;

  // Upstream side: drives the M stage, sees stall and writeback results
  modport master (
    output ALUResultM, writeDataM, writeRegM, regWriteM, memWriteM, mem2regM,
           sizeM, unsignedM, flushM, zeroM, branchM,
    input  stallM, PCSrcM, readDataW, ALUResultW, writeRegW, regWriteW,
           mem2regW, memWriteW, misalignW
  );

  // Memory stage side
  modport slave (
    input  ALUResultM, writeDataM, writeRegM, regWriteM, memWriteM, mem2regM,
           sizeM, unsignedM, flushM, zeroM, branchM,
    output stallM, PCSrcM, readDataW, ALUResultW, writeRegW, regWriteW,
           mem2regW, memWriteW, misalignW
  );
endinterface

// File: rtl/mem_stage_ls_lane_align.sv
// Byte-lane alignment: load extract/extend, store replicate and byte enables,
// plus natural-alignment check. Purely combinational.
module mem_stage_ls_lane_align
  import mem_stage_ls_pkg::*;
#(
  parameter  int WORD = 32,
  localparam int NB   = WORD / 8,
  localparam int OFF  = $clog2(NB)
) (
  input  logic [1:0]      size,
  input  logic [OFF-1:0]  offset,
  input  logic            zero_ext,
  input  logic [WORD-1:0] rdata,
  input  logic [WORD-1:0] wdata,
  output logic [WORD-1:0] load_data,
  output logic [WORD-1:0] store_data,
  output logic [NB-1:0]   byte_en,
  output logic            misalign
);

  int              nbytes;
  int              nbits;
  logic [WORD-1:0] shifted;
  logic            ext;

  // Access width in bytes
  always_comb begin
    case (size_e'(size))
      SZ_BYTE: nbytes = 1;
      SZ_HALF: nbytes = 2;
      SZ_WORD: nbytes = 4;
      default: nbytes = 8;
    endcase
  end

  // Wider than the datapath (dword on a 32-bit build) counts as misaligned
  assign misalign = (nbytes > NB) || ((int'(offset) % nbytes) != 0);

  // Load: shift selected lanes to bit 0, then sign- or zero-extend
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    nbits   = 8 * ((nbytes > NB) ? NB : nbytes);
    ext     = ~zero_ext & shifted[nbits-1];
    for (int i = 0; i < WORD; i++)
      load_data[i] = (i < nbits) ? shifted[i] : ext;
  end

  // Store: replicate the low bytes across all lanes, enable only the target ones
  always_comb begin
    store_data = '0;
    byte_en    = '0;
    for (int b = 0; b < NB; b++) begin
      store_data[8*b +: 8] = wdata[8*(b % nbytes) +: 8];
      byte_en[b]           = (b >= int'(offset)) && (b < int'(offset) + nbytes);
    end
  end

endmodule

// File: rtl/mem_stage_ls.sv
// Pipeline memory stage: byte-addressed data RAM with sized loads/stores,
// optional wait states with stall, and a flushable MEM/WB register.
module mem_stage_ls
  import mem_stage_ls_pkg::*;
#(
  parameter int WORD       = 32,
  parameter int REG_SIZE   = 5,
  parameter int DMEM_POWER = 18,
  parameter int MEM_LAT    = 0
) (
  input  logic           clk,
  input  logic           reset,
  mem_stage_ls_if.slave  bus
);

  localparam int NB  = WORD / 8;
  localparam int OFF = $clog2(NB);
  localparam int MW  = memwb_width(WORD, REG_SIZE);
  localparam int CW  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [WORD-1:0]       mem [2**DMEM_POWER];

  logic [DMEM_POWER-1:0] idx;
  logic [OFF-1:0]        off;
  logic [WORD-1:0]       rd_word;
  logic [WORD-1:0]       load_data;
  logic [WORD-1:0]       store_data;
  logic [NB-1:0]         byte_en;
  logic                  lane_mis;
  logic                  access;
  logic                  misaligned;
  logic                  start;
  logic                  wr_en;
  logic                  capture;
  state_e                state;
  logic [CW-1:0]         cnt;
  logic [MW-1:0]         wb_d;
  logic [MW-1:0]         wb_q;

  assign idx     = bus.ALUResultM[DMEM_POWER+OFF-1:OFF];
  assign off     = bus.ALUResultM[OFF-1:0];
  assign rd_word = mem[idx];

  mem_stage_ls_lane_align #(.WORD(WORD)) u_align (
    .size       (bus.sizeM),
    .offset     (off),
    .zero_ext   (bus.unsignedM),
    .rdata      (rd_word),
    .wdata      (bus.writeDataM),
    .load_data  (load_data),
    .store_data (store_data),
    .byte_en    (byte_en),
    .misalign   (lane_mis)
  );

  assign access     = bus.memWriteM | bus.mem2regM;
  assign misaligned = access & lane_mis;

  // Only aligned RAM accesses wait; misaligned ones are trapped without touching RAM
  assign start = (MEM_LAT > 0) & (state == IDLE) & access & ~lane_mis
               & ~bus.flushM & ~reset;

  assign bus.stallM = start | (state == BUSY);
  assign bus.PCSrcM = bus.zeroM & bus.branchM;

  // Single write slot: same cycle when there are no wait states, else the DONE cycle
  assign wr_en = bus.memWriteM & ~misaligned & ~bus.flushM & ~reset
               & ((MEM_LAT == 0) ? (state == IDLE) : (state == DONE));

  // Wait-state sequencer; DONE is entered on the cycle the counter reaches zero,
  // so an access occupies the stage for MEM_LAT+1 cycles in total
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (bus.flushM) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt   <= CW'(MEM_LAT - 1);
          state <= (MEM_LAT == 1) ? DONE : BUSY;
        end
        BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Byte-lane RAM write; contents intentionally have no reset
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int b = 0; b < NB; b++)
        if (byte_en[b]) mem[idx][8*b +: 8] <= store_data[8*b +: 8];
  end

  // readDataW carries load data only; stores, non-memory ops and traps give 0
  assign capture = ~bus.stallM & ~bus.flushM;
  assign wb_d = capture ?
    { (bus.mem2regM & ~misaligned) ? load_data : {WORD{1'b0}},
      bus.ALUResultM, bus.writeRegM,
      bus.regWriteM & ~misaligned, bus.mem2regM, bus.memWriteM, misaligned }
    : '0;

  // MEM/WB register: loads a bubble while stalled or flushed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wb_q <= '0;
    else       wb_q <= wb_d;
  end

  assign {bus.readDataW, bus.ALUResultW, bus.writeRegW,
          bus.regWriteW, bus.mem2regW, bus.memWriteW, bus.misalignW} = wb_q;

endmodule

// File: tb/tb_mem_stage_ls.sv
// Bench for mem_stage_ls: one instance without wait states, one with MEM_LAT=3,
// checked every cycle against a transaction-level model plus literal expectations.
module tb_mem_stage_ls;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        rw, mw, m2r;
    logic [1:0]  sz;
    logic        uns, flush, zero, br;
  } op_t;

  typedef struct packed {
    logic [31:0] rdat;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic        rw, m2r, mw, mis;
  } w_t;

  mem_stage_ls_if #(.WORD(32), .REG_SIZE(5)) b0 ();
  mem_stage_ls_if #(.WORD(32), .REG_SIZE(5)) b3 ();

  mem_stage_ls #(.WORD(32), .REG_SIZE(5), .DMEM_POWER(8), .MEM_LAT(0)) u0 (
    .clk(clk), .reset(reset), .bus(b0.slave));
  mem_stage_ls #(.WORD(32), .REG_SIZE(5), .DMEM_POWER(8), .MEM_LAT(3)) u3 (
    .clk(clk), .reset(reset), .bus(b3.slave));

  op_t in_q [2];

  assign b0.ALUResultM = in_q[0].addr;
  assign b0.writeDataM = in_q[0].wdata;
  assign b0.writeRegM  = in_q[0].rd;
  assign b0.regWriteM  = in_q[0].rw;
  assign b0.memWriteM  = in_q[0].mw;
  assign b0.mem2regM   = in_q[0].m2r;
  assign b0.sizeM      = in_q[0].sz;
  assign b0.unsignedM  = in_q[0].uns;
  assign b0.flushM     = in_q[0].flush;
  assign b0.zeroM      = in_q[0].zero;
  assign b0.branchM    = in_q[0].br;

  assign b3.ALUResultM = in_q[1].addr;
  assign b3.writeDataM = in_q[1].wdata;
  assign b3.writeRegM  = in_q[1].rd;
  assign b3.regWriteM  = in_q[1].rw;
  assign b3.memWriteM  = in_q[1].mw;
  assign b3.mem2regM   = in_q[1].m2r;
  assign b3.sizeM      = in_q[1].sz;
  assign b3.unsignedM  = in_q[1].uns;
  assign b3.flushM     = in_q[1].flush;
  assign b3.zeroM      = in_q[1].zero;
  assign b3.branchM    = in_q[1].br;

  // ---------------- model state ----------------
  int          lat [2] = '{0, 3};
  int          waited [2];        // cycles the current access has already waited
  w_t          cur_w [2];         // what W must show now
  w_t          nxt_w [2];         // what W must show after the next edge
  logic        exp_stall [2];
  logic        exp_pc [2];
  logic [7:0]  mb [int];          // byte-addressed memory image, keyed per instance
  logic        rst_req;
  int          n_chk = 0;
  int          n_err = 0;
  bit          chk_en = 0;
  int          mw3_seen;

  localparam op_t NOP = '0;

  function automatic op_t mk(input logic mw, input logic m2r, input logic rw,
                             input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [4:0] rd);
    op_t o = '0;
    o.mw = mw; o.m2r = m2r; o.rw = rw; o.sz = sz; o.uns = uns;
    o.addr = addr; o.wdata = wd; o.rd = rd;
    return o;
  endfunction

  function automatic op_t st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    return mk(1'b1, 1'b0, 1'b0, sz, 1'b0, a, d, 5'd0);
  endfunction

  function automatic op_t ld(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                             input logic [4:0] rd);
    return mk(1'b0, 1'b1, 1'b1, sz, uns, a, 32'h0, rd);
  endfunction

  function automatic w_t dut_w(input int s);
    if (s == 0)
      return {b0.readDataW, b0.ALUResultW, b0.writeRegW, b0.regWriteW,
              b0.mem2regW, b0.memWriteW, b0.misalignW};
    return {b3.readDataW, b3.ALUResultW, b3.writeRegW, b3.regWriteW,
            b3.mem2regW, b3.memWriteW, b3.misalignW};
  endfunction

  function automatic logic dut_stall(input int s);
    return (s == 0) ? b0.stallM : b3.stallM;
  endfunction

  function automatic logic dut_pc(input int s);
    return (s == 0) ? b0.PCSrcM : b3.PCSrcM;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One instruction-cycle of the model: stall rule, trap rule, memory semantics
  task automatic model_step(input int s);
    op_t         o;
    int          n;
    int          key;
    logic        acc;
    logic        mis;
    logic [63:0] v;
    o   = in_q[s];
    acc = o.mw | o.m2r;
    n   = 1 << o.sz;
    mis = acc && ((n > 4) || ((o.addr % n) != 0));
    exp_pc[s]    = o.zero & o.br;
    exp_stall[s] = 1'b0;
    nxt_w[s]     = '0;
    if (reset) begin
      waited[s] = 0;
    end else if (waited[s] > 0 && waited[s] < lat[s]) begin
      exp_stall[s] = 1'b1;
      waited[s]    = o.flush ? 0 : waited[s] + 1;
    end else if (waited[s] == 0 && acc && !mis && !o.flush && lat[s] > 0) begin
      exp_stall[s] = 1'b1;
      waited[s]    = 1;
    end else begin
      waited[s] = 0;
      if (!o.flush) begin
        nxt_w[s].alu  = o.addr;
        nxt_w[s].wreg = o.rd;
        nxt_w[s].rw   = o.rw & ~mis;
        nxt_w[s].m2r  = o.m2r;
        nxt_w[s].mw   = o.mw;
        nxt_w[s].mis  = mis;
        if (o.m2r && !mis) begin
          v = '0;
          for (int i = 0; i < n; i++) begin
            key = s * 4096 + int'((o.addr + i) & 32'h3FF);
            v   = v | (64'(mb.exists(key) ? mb[key] : 8'h00) << (8 * i));
          end
          if (!o.uns && v[8*n-1]) v = v | (~64'h0 << (8 * n));
          nxt_w[s].rdat = v[31:0];
        end
        if (o.mw && !mis)
          for (int i = 0; i < n; i++) begin
            key     = s * 4096 + int'((o.addr + i) & 32'h3FF);
            mb[key] = o.wdata[8*i +: 8];
          end
      end
    end
  endtask

  // Advance one clock and present new inputs to both instances
  task automatic tick(input op_t a0, input op_t a1);
    @(posedge clk);
    #1;
    reset = rst_req;
    for (int s = 0; s < 2; s++) cur_w[s] = nxt_w[s];
    if (b3.memWriteW) mw3_seen++;
    in_q[0] = a0;
    in_q[1] = a1;
    model_step(0);
    model_step(1);
  endtask

  // Present an op and hold it while the stage stalls; returns stalled cycles
  task automatic issue(input int s, input op_t o, output int nst);
    nst = 0;
    if (s == 0) tick(o, NOP); else tick(NOP, o);
    #1;
    while (dut_stall(s)) begin
      if (nst >= 20) begin
        n_chk++; n_err++;
        $display("FAIL stall_timeout: got stall after %0d cycles expected release", nst);
        break;
      end
      nst++;
      if (s == 0) tick(o, NOP); else tick(NOP, o);
      #1;
    end
  endtask

  // Issue, then one more edge so the result is visible on W
  task automatic xfer(input int s, input op_t o, output int nst);
    issue(s, o, nst);
    tick(NOP, NOP);
    #1;
  endtask

  // Reset pulse raised between clock edges
  task automatic async_reset();
    #1;
    reset   = 1'b1;
    rst_req = 1'b1;
    for (int s = 0; s < 2; s++) begin
      cur_w[s] = '0; nxt_w[s] = '0; waited[s] = 0; exp_stall[s] = 1'b0;
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int s = 0; s < 2; s++) begin
        chk($sformatf("w_lat%0d", lat[s]), 128'(dut_w(s)), 128'(cur_w[s]));
        chk($sformatf("stall_lat%0d", lat[s]), 128'(dut_stall(s)), 128'(exp_stall[s]));
        chk($sformatf("pcsrc_lat%0d", lat[s]), 128'(dut_pc(s)), 128'(exp_pc[s]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int   ns;
    op_t  o;
    rst_req  = 1'b1;
    in_q[0]  = NOP;
    in_q[1]  = NOP;
    mw3_seen = 0;
    for (int s = 0; s < 2; s++) begin
      waited[s] = 0; cur_w[s] = '0; nxt_w[s] = '0; exp_stall[s] = 0; exp_pc[s] = 0;
    end
    tick(NOP, NOP);
    chk_en = 1;
    #1;
    chk("rst_w0", 128'(dut_w(0)), 128'(0));
    chk("rst_stall3", 128'(b3.stallM), 128'(0));
    rst_req = 1'b0;
    tick(NOP, NOP);

    // 1: word store, signed/unsigned byte loads
    xfer(0, st(2'b10, 32'h10, 32'hDEADBEEF), ns);
    chk("t1_sw_nostall", 128'(ns), 128'(0));
    xfer(0, ld(2'b00, 1'b0, 32'h13, 5'd1), ns);
    chk("t1_lb_signed", 128'(b0.readDataW), 128'(32'hFFFFFFDE));
    xfer(0, ld(2'b00, 1'b1, 32'h13, 5'd1), ns);
    chk("t1_lbu", 128'(b0.readDataW), 128'(32'h000000DE));

    // 2: half store into upper lanes
    xfer(0, st(2'b01, 32'h12, 32'h00001234), ns);
    xfer(0, ld(2'b01, 1'b0, 32'h12, 5'd2), ns);
    chk("t2_lh_upper", 128'(b0.readDataW), 128'(32'h00001234));
    xfer(0, ld(2'b10, 1'b0, 32'h10, 5'd2), ns);
    chk("t2_lw_merged", 128'(b0.readDataW), 128'(32'h1234BEEF));
    xfer(0, ld(2'b01, 1'b0, 32'h10, 5'd2), ns);
    chk("t2_lh_neg", 128'(b0.readDataW), 128'(32'hFFFFBEEF));

    // 3: misaligned accesses trap and leave RAM alone
    xfer(0, ld(2'b10, 1'b0, 32'h11, 5'd4), ns);
    chk("t3_mis_flag", 128'(b0.misalignW), 128'(1));
    chk("t3_mis_regw", 128'(b0.regWriteW), 128'(0));
    chk("t3_mis_data", 128'(b0.readDataW), 128'(0));
    xfer(0, st(2'b01, 32'h13, 32'h0000FFFF), ns);
    xfer(0, ld(2'b11, 1'b0, 32'h10, 5'd4), ns);
    chk("t3_dword_mis", 128'(b0.misalignW), 128'(1));
    xfer(0, st(2'b00, 32'h11, 32'h0000005A), ns);
    xfer(0, ld(2'b10, 1'b0, 32'h10, 5'd4), ns);
    chk("t3_sb_merged", 128'(b0.readDataW), 128'(32'h12345AEF));

    // Branch resolve and non-memory pass-through on the wait-state instance
    o = NOP; o.zero = 1'b1; o.br = 1'b1;
    tick(o, NOP);
    #1;
    chk("pcsrc_taken", 128'(b0.PCSrcM), 128'(1));
    xfer(1, mk(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000ABCD, 32'h0, 5'd7), ns);
    chk("alu_nostall", 128'(ns), 128'(0));
    chk("alu_pass", 128'(b3.ALUResultW), 128'(32'h0000ABCD));
    xfer(1, ld(2'b10, 1'b0, 32'h22, 5'd7), ns);
    chk("lat3_mis_nostall", 128'(ns), 128'(0));

    // 4: store with wait states
    mw3_seen = 0;
    xfer(1, st(2'b10, 32'h20, 32'hCAFEF00D), ns);
    chk("t4_stall_cycles", 128'(ns), 128'(3));
    tick(NOP, NOP);
    tick(NOP, NOP);
    chk("t4_memwrite_once", 128'(mw3_seen), 128'(1));
    xfer(1, ld(2'b10, 1'b0, 32'h20, 5'd3), ns);
    chk("t4_load_back", 128'(b3.readDataW), 128'(32'hCAFEF00D));

    // 5: flush during the second busy cycle
    o = ld(2'b10, 1'b0, 32'h20, 5'd3);
    tick(NOP, o);
    tick(NOP, o);
    o.flush = 1'b1;
    tick(NOP, o);
    tick(NOP, NOP);
    #1;
    chk("t5_stall_drop", 128'(b3.stallM), 128'(0));
    chk("t5_bubble", 128'(dut_w(1)), 128'(0));
    xfer(1, st(2'b10, 32'h24, 32'h11223344), ns);
    chk("t5_next_stall", 128'(ns), 128'(3));
    xfer(1, ld(2'b10, 1'b0, 32'h24, 5'd5), ns);
    chk("t5_next_data", 128'(b3.readDataW), 128'(32'h11223344));

    // 6: reset while a store is waiting
    tick(ld(2'b10, 1'b0, 32'h10, 5'd9), st(2'b10, 32'h20, 32'h55555555));
    tick(NOP, st(2'b10, 32'h20, 32'h55555555));
    async_reset();
    #1;
    chk("t6_regw_cleared", 128'(b0.regWriteW), 128'(0));
    chk("t6_data_cleared", 128'(b0.readDataW), 128'(0));
    chk("t6_stall_low", 128'(b3.stallM), 128'(0));
    tick(NOP, NOP);
    rst_req = 1'b0;
    tick(NOP, NOP);
    xfer(1, ld(2'b10, 1'b0, 32'h20, 5'd6), ns);
    chk("t6_old_data", 128'(b3.readDataW), 128'(32'hCAFEF00D));

    tick(NOP, NOP);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_stage_ls.md
Name: mem_stage_ls

Overview:
Next-generation pipeline memory stage with byte/half/word(/dword) loads and stores, sign/zero extension and misalignment detection. Also provides a configurable memory access latency with a stall output, and a MEM/WB pipeline register that supports flush. It sits between the execute stage and writeback, and keeps the branch-resolve output PCSrcM.

Parameters:
WORD, 32, datapath width in bits; legal values are 32 or 64.
REG_SIZE, 5, register index width.
DMEM_POWER, 18, log2 of the number of WORD-wide RAM entries.
MEM_LAT, 0, extra wait cycles per aligned access; 0 means single-cycle access.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
ALUResultM  in  WORD  byte address, or result passed through to writeback
writeDataM  in  WORD  store data, right-aligned
writeRegM  in  REG_SIZE  destination register
regWriteM, memWriteM, mem2regM  in  1 each  control bits
sizeM  in  2  access size: 00 byte, 01 half, 10 word, 11 dword (legal only when WORD=64)
unsignedM  in  1  1 = zero-extend loads, 0 = sign-extend loads
flushM  in  1  kill the instruction currently in M
zeroM, branchM  in  1 each  branch condition inputs
stallM  out  1  upstream must hold M inputs stable while this is high
PCSrcM  out  1  zeroM & branchM, combinational
readDataW, ALUResultW  out  WORD  registered outputs
writeRegW  out  REG_SIZE  registered output
regWriteW, mem2regW, memWriteW, misalignW  out  1 each  registered outputs

Behaviour:
- Single clock (clk). Reset is asynchronous and active-high. On reset:
  - all W outputs are 0
  - FSM goes to IDLE, wait counter is 0
  - stallM is 0
  - RAM contents are not reset
- Addressing:
  - OFF = log2(WORD/8)
  - word index = ALUResultM[DMEM_POWER+OFF-1:OFF]
  - byte offset = ALUResultM[OFF-1:0]
  - upper address bits are ignored
- Misaligned access (the access is a load or store, i.e. memWriteM or mem2regM):
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - dword with addr[2:0]!=0
  - sizeM=11 when WORD=32 is also treated as misaligned
  - Effect: no RAM write, no stall, readDataW=0, misalignW=1, regWriteW forced to 0; other fields pass through.
- Store: byte-lane write enables per size and offset; writeDataM's low bytes are replicated into the selected lanes; unselected lanes keep their old value.
- Load: the selected lanes are extracted, shifted to bit 0, then sign- or zero-extended to WORD per unsignedM.
- FSM states:
  - IDLE: an aligned access with MEM_LAT>0 and no flushM -> BUSY; counter loads MEM_LAT-1 and stallM=1 in this cycle.
  - BUSY: stallM=1; counter decrements each cycle; when counter=0 -> DONE.
  - DONE: stallM=0; the RAM write, if any, commits at this clock edge; read data is sampled and the MEM/WB register captures the result; next state is IDLE.
  - Total occupancy is MEM_LAT+1 cycles.
- MEM_LAT=0: the FSM stays in IDLE. The write commits at the clock edge of the same cycle; the read is combinational from RAM, giving read-before-write behaviour in that cycle.
- While stallM=1 the MEM/WB register loads a bubble: regWriteW, mem2regW, memWriteW and misalignW are 0, data fields are don't-care (they are driven to 0).
- Non-memory instructions (neither memWriteM nor mem2regM) never stall; they pass through in 1 cycle.
- flushM:
  - The MEM/WB register loads a bubble at the next edge.
  - Any pending write is suppressed.
  - The FSM returns to IDLE from any state.
  - flushM has priority over completion in DONE.
- The register captures exactly once per instruction; upstream holding inputs must not cause a double write.
- Reset mid-BUSY: the access is abandoned and no write occurs.

Decomposition:
- Shared package: access-size enum SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD, FSM state enum IDLE/BUSY/DONE, and the MEM/WB field-layout width constant.
- Sub-module lane_align: a combinational load-extract/extend plus store-replicate/byte-enable generator, reusable by the later cache block.
- The MEM/WB register uses the existing reset flop with an added load-bubble mux.

Test Plan:
1. MEM_LAT=0, WORD=32: store word 0xDEADBEEF at 0x10, then load byte at 0x13 signed -> readDataW=0xFFFFFFDE; load unsigned -> 0x000000DE.
2. Store half 0x1234 at 0x12 over 0xDEADBEEF -> RAM word 0x1234BEEF; load half at 0x12 signed -> 0x00001234.
3. Load word at 0x11 -> misalignW=1, regWriteW=0, readDataW=0, RAM unchanged, no stall.
4. MEM_LAT=3 store at 0x20: stallM high for exactly 3 cycles, 4th cycle low; W bubbles for 3 cycles; exactly one RAM write; memWriteW=1 once.
5. MEM_LAT=3 load, flushM in the 2nd BUSY cycle -> FSM back to IDLE, stallM low next cycle, W bubble; a following store proceeds normally.
6. Assert reset during BUSY of a store -> all W outputs 0 immediately (asynchronous), stallM=0, and a later load of that address returns the old data.
